// File: rtl/reg_map_pkg.sv
// Shared definitions for the register-map responder.
//   - FSM state encoding for the request/response handshake.
//   - Byte-offset helpers for every register in the map, derived from the
//     number of control registers.
//   - Error-cause bits, OR-ed together by the address decoder.
package reg_map_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Error causes form a bitmask so several can be flagged at once.
  localparam logic [2:0] ERR_NONE      = 3'b000;
  localparam logic [2:0] ERR_UNALIGNED = 3'b001;
  localparam logic [2:0] ERR_RANGE     = 3'b010;
  localparam logic [2:0] ERR_RO_WRITE  = 3'b100;

  function automatic int unsigned ctrl_offset(input int unsigned idx);
    return WORD_BYTES * idx;
  endfunction

  function automatic int unsigned status_offset(input int unsigned num_ctrl);
    return WORD_BYTES * num_ctrl;
  endfunction

  function automatic int unsigned intr_stat_offset(input int unsigned num_ctrl);
    return status_offset(num_ctrl) + WORD_BYTES;
  endfunction

  function automatic int unsigned intr_en_offset(input int unsigned num_ctrl);
    return status_offset(num_ctrl) + 2 * WORD_BYTES;
  endfunction

endpackage

// File: rtl/reg_map_intr_bank.sv
// Sticky interrupt block: INTR_STAT (write-1-to-clear, set by hardware
// pulses), INTR_EN (read/write with bit enables) and a registered level irq.
// Ports:
//   clk, rst        clock and async active-low reset
//   stat_we, en_we  accepted bus write to INTR_STAT / INTR_EN this cycle
//   wr_data, biten  bus write data and per-bit write enable
//   intr_set        per-bit hardware set pulses
//   intr_stat       current INTR_STAT
//   intr_en         current INTR_EN
//   irq             registered OR of (INTR_STAT & INTR_EN)
module reg_map_intr_bank #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stat_we,
  input  logic                  en_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] biten,
  input  logic [DATA_WIDTH-1:0] intr_set,
  output logic [DATA_WIDTH-1:0] intr_stat,
  output logic [DATA_WIDTH-1:0] intr_en,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] clr_mask;

  assign clr_mask = stat_we ? (wr_data & biten) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr_stat <= '0;
      intr_en   <= '0;
      irq       <= 1'b0;
    end else begin
      // Set is OR-ed in after the clear, so a coincident set wins.
      intr_stat <= (intr_stat & ~clr_mask) | intr_set;
      if (en_we) begin
        intr_en <= (intr_en & ~biten) | (wr_data & biten);
      end
      // Built from the registered values, giving set -> irq in two cycles.
      irq <= |(intr_stat & intr_en);
    end
  end

endmodule

// File: rtl/reg_map_responder.sv
// Register-map endpoint behind the AXI4-Lite bridge request channel.
// Accepts one-cycle read/write strobes and answers one cycle later with
// read data or an error.
// Map (byte addresses): CTRL[i] at 4*i, STATUS at 4*NUM_CTRL (read-only),
// INTR_STAT at +4 (W1C), INTR_EN at +8 (RW).
// Build option: define REG_MAP_RESP_INTR_EN to include the interrupt block;
// without it the two interrupt addresses return bus_err and irq is 0.
// Ports:
//   clk, rst                     clock, async active-low reset
//   bus_req, bus_req_is_wr       request strobe and direction
//   bus_addr, bus_wr_data        byte address and write data
//   bus_wr_biten                 per-bit write enable
//   bus_ready, bus_rd_data       response strobe and read data
//   bus_err                      response error flag
//   hw_ctrl                      control registers, slice i = CTRL[i]
//   hw_status                    live status word
//   hw_intr_set                  interrupt set pulses
//   irq                          level interrupt
module reg_map_responder
  import reg_map_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CTRL   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bus_req,
  input  logic                           bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]          bus_addr,
  input  logic [DATA_WIDTH-1:0]          bus_wr_data,
  input  logic [DATA_WIDTH-1:0]          bus_wr_biten,
  output logic                           bus_ready,
  output logic [DATA_WIDTH-1:0]          bus_rd_data,
  output logic                           bus_err,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] hw_ctrl,
  input  logic [DATA_WIDTH-1:0]          hw_status,
  input  logic [DATA_WIDTH-1:0]          hw_intr_set,
  output logic                           irq
);

  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(status_offset(NUM_CTRL));

  state_t                             state;
  logic [NUM_CTRL-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [3:0]                         ctrl_idx;
  logic                               aligned;
  logic                               hit_ctrl;
  logic                               hit_status;
  logic                               hit_stat;
  logic                               hit_en;
  logic [2:0]                         err_cause;
  logic                               wr_ok;
  logic [DATA_WIDTH-1:0]              rd_next;
  logic [DATA_WIDTH-1:0]              intr_stat;
  logic [DATA_WIDTH-1:0]              intr_en;

  assign aligned    = (bus_addr[1:0] == 2'b00);
  assign ctrl_idx   = bus_addr[5:2];
  assign hit_ctrl   = aligned && (bus_addr < STATUS_ADDR);
  assign hit_status = (bus_addr == STATUS_ADDR);
  assign bus_ready  = (state == RESP);
  assign hw_ctrl    = ctrl_q;

`ifdef REG_MAP_RESP_INTR_EN
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(intr_stat_offset(NUM_CTRL));
  localparam logic [ADDR_WIDTH-1:0] EN_ADDR   = ADDR_WIDTH'(intr_en_offset(NUM_CTRL));

  assign hit_stat = (bus_addr == STAT_ADDR);
  assign hit_en   = (bus_addr == EN_ADDR);

  reg_map_intr_bank #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_intr_bank (
    .clk      (clk),
    .rst      (rst),
    .stat_we  (wr_ok && hit_stat),
    .en_we    (wr_ok && hit_en),
    .wr_data  (bus_wr_data),
    .biten    (bus_wr_biten),
    .intr_set (hw_intr_set),
    .intr_stat(intr_stat),
    .intr_en  (intr_en),
    .irq      (irq)
  );
`else
  logic unused_intr_set;

  assign hit_stat        = 1'b0;
  assign hit_en          = 1'b0;
  assign intr_stat       = '0;
  assign intr_en         = '0;
  assign irq             = 1'b0;
  assign unused_intr_set = ^hw_intr_set;
`endif

  // Decode and read mux.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    err_cause = ERR_NONE;
    rd_next   = '0;
    if (!aligned) begin
      err_cause = err_cause | ERR_UNALIGNED;
    end
    if (!(hit_ctrl || hit_status || hit_stat || hit_en)) begin
      err_cause = err_cause | ERR_RANGE;
    end
    if (hit_status && bus_req_is_wr) begin
      err_cause = err_cause | ERR_RO_WRITE;
    end
    if (!bus_req_is_wr && err_cause == ERR_NONE) begin
      if (hit_status) rd_next = hw_status;
      if (hit_stat)   rd_next = intr_stat;
      if (hit_en)     rd_next = intr_en;
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (hit_ctrl && ctrl_idx == 4'(i)) rd_next = ctrl_q[i];
      end
    end
  end

  assign wr_ok = bus_req && bus_req_is_wr && (err_cause == ERR_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the control bank is a handful of flops, not a RAM, so it is
      // reset like any other state to give hardware a known configuration.
      state       <= IDLE;
      bus_rd_data <= '0;
      bus_err     <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE:    if (bus_req)  state <= RESP;
        RESP:    if (!bus_req) state <= IDLE;
        default: state <= IDLE;
      endcase
      bus_rd_data <= bus_req ? rd_next : '0;
      bus_err     <= bus_req && (err_cause != ERR_NONE);
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (wr_ok && hit_ctrl && ctrl_idx == 4'(i)) begin
          ctrl_q[i] <= (ctrl_q[i] & ~bus_wr_biten) | (bus_wr_data & bus_wr_biten);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_map_responder.sv
module tb_reg_map_responder;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_req, bus_req_is_wr;
  logic [31:0]   bus_addr, bus_wr_data, bus_wr_biten;
  logic          bus_ready, bus_err, irq;
  logic [31:0]   bus_rd_data;
  logic [NC*32-1:0] hw_ctrl;
  logic [31:0]   hw_status, hw_intr_set;

  reg_map_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CTRL(NC)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_ready(bus_ready), .bus_rd_data(bus_rd_data), .bus_err(bus_err),
    .hw_ctrl(hw_ctrl), .hw_status(hw_status), .hw_intr_set(hw_intr_set), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rd; logic err; } resp_t;
  resp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: register contents as the map defines them.
  logic [31:0] ctrl_m [NC];
  logic [31:0] stat_m, en_m;
  logic        ready_m, irq_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) ctrl_m[i] = '0;
    stat_m = '0; en_m = '0; ready_m = 1'b0; irq_m = 1'b0;
  endtask

  // One bus cycle: drive, predict the response, advance the model.
  task automatic cycle(input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] biten,
                       input logic [31:0] status, input logic [31:0] iset);
    logic [31:0] n_ctrl [NC];
    logic [31:0] n_stat, n_en, rd;
    logic        bad, irq_next;
    int unsigned word;
    bus_req = req; bus_req_is_wr = wr; bus_addr = addr; bus_wr_data = data;
    bus_wr_biten = biten; hw_status = status; hw_intr_set = iset;
    n_ctrl = ctrl_m; n_stat = stat_m; n_en = en_m; rd = '0; bad = 1'b0;
    word = addr / 4;
    if (req) begin
      if (addr % 4 != 0) bad = 1'b1;
      else if (word < NC) begin
        if (wr) n_ctrl[word] = (ctrl_m[word] & ~biten) | (data & biten);
        else rd = ctrl_m[word];
      end else if (word == NC) begin
        if (wr) bad = 1'b1; else rd = status;
      end
`ifdef REG_MAP_RESP_INTR_EN
      else if (word == NC + 1) begin
        if (wr) n_stat = stat_m & ~(data & biten); else rd = stat_m;
      end else if (word == NC + 2) begin
        if (wr) n_en = (en_m & ~biten) | (data & biten); else rd = en_m;
      end
`endif
      else bad = 1'b1;
      q.push_back('{rd: rd, err: bad});
    end
`ifdef REG_MAP_RESP_INTR_EN
    n_stat   = n_stat | iset;
    irq_next = |(stat_m & en_m);
`else
    irq_next = 1'b0;
`endif
    @(posedge clk); #1;
    ctrl_m = n_ctrl; stat_m = n_stat; en_m = n_en;
    ready_m = req; irq_m = irq_next;
    bus_req = 1'b0; hw_intr_set = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] biten);
    cycle(1'b1, 1'b1, addr, data, biten, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    cycle(1'b1, 1'b0, addr, 32'h0, 32'h0, $urandom, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: compares every response and the hardware-facing outputs.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      check("bus_ready", 32'(bus_ready), 32'(ready_m));
      if (bus_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got ready with no request pending at %0t", $time);
        end else begin
          e = q.pop_front();
          check("rd_data", bus_rd_data, e.rd);
          check("bus_err", 32'(bus_err), 32'(e.err));
        end
      end
      for (int i = 0; i < NC; i++) check("hw_ctrl", hw_ctrl[i*32 +: 32], ctrl_m[i]);
      check("irq", 32'(irq), 32'(irq_m));
    end
  end

  initial begin
    logic [31:0] a, bt;
    clear_model();
    rst = 1'b0; bus_req = 1'b0; bus_req_is_wr = 1'b0; bus_addr = '0;
    bus_wr_data = '0; bus_wr_biten = '0; hw_status = '0; hw_intr_set = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", bus_rd_data, 32'h0);
    check("reset_err", 32'(bus_err), 32'h0);
    rst = 1'b1;
    idle(1);

    // Full write then readback of CTRL[1].
    wr(32'h4, 32'hDEADBEEF, 32'hFFFFFFFF);
    rd(32'h4);
    // Partial write through bit enables.
    wr(32'h0, 32'hFFFF0000, 32'hFFFFFFFF);
    wr(32'h0, 32'h12345678, 32'h0000FF00);
    rd(32'h0);
    // Zero-enable write is a legal no-op.
    wr(32'h0, 32'hFFFFFFFF, 32'h0);
    rd(32'h0);
    // Error cases.
    rd(32'h2);
    rd(32'h40);
    wr(32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycle(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'hA5A5_5A5A, 32'h0);
    rd(32'h14);
    wr(32'h18, 32'h4, 32'hFFFFFFFF);
    idle(1);

`ifdef REG_MAP_RESP_INTR_EN
    // Set pulse with enable on bit 2: irq two cycles later.
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5);
    idle(3);
    // Clear coincident with set: set wins.
    cycle(1'b1, 1'b1, 32'h14, 32'h4, 32'hFFFFFFFF, 32'h0, 32'h4);
    rd(32'h14);
    idle(2);
    // Clear without set: irq drops.
    wr(32'h14, 32'h4, 32'hFFFFFFFF);
    rd(32'h14);
    idle(3);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, (NC + 4) * 4 - 1));
        default: a = 32'($urandom_range(0, NC + 3)) * 4;
      endcase
      case ($urandom_range(0, 3))
        0:       bt = 32'h0;
        1:       bt = 32'hFFFFFFFF;
        default: bt = $urandom;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, $urandom, bt,
            $urandom, $urandom & $urandom & $urandom);
    end
    idle(2);

    // Back-to-back: two writes and a read.
    wr(32'h8, 32'hCAFE_F00D, 32'hFFFFFFFF);
    wr(32'hC, 32'h0BAD_F00D, 32'hFFFFFFFF);
    rd(32'h8);
    idle(1);

    // Reset coincident with a read strobe: no response may appear.
    bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 32'h8; rst = 1'b0;
    q.delete();
    clear_model();
    repeat (2) begin @(posedge clk); #1; end
    bus_req = 1'b0; rst = 1'b1;
    idle(1);
    for (int i = 0; i < NC + 3; i++) rd(32'(i * 4));
    idle(3);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
